// File: rtl/mmbuf_lsu.sv
// Memory-request buffer and load/store unit: queues ALU memory requests, issues them
// one at a time on a req/gnt data bus, and writes load results back to the register file.
module mmbuf_lsu #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mem_vld,
   input  logic [9:0]      mem_para,
   input  logic [XLEN-1:0] mem_addr,
   input  logic [XLEN-1:0] mem_wdata,
   output logic            mmbuf_full,
   output logic            mmbuf_empty,
   output logic [31:0]     busy_mask,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   input  logic            dmem_gnt,
   input  logic            dmem_rvld,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic [4:0]      wb_sel,
   output logic [XLEN-1:0] wb_data,
   output logic            err_misalign,
   output logic            err_drop
);

   // state   | meaning
   // ST_IDLE | no bus transaction; pops the head entry when the FIFO is non-empty
   // ST_REQ  | dmem_req high, bus outputs frozen until dmem_gnt
   // ST_WAIT | load granted, waiting for dmem_rvld

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic            dmem_req_q, dmem_req_d;
   logic            dmem_we_q, dmem_we_d;
   logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
   logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;
   logic [3:0]      dmem_be_q, dmem_be_d;
   logic [4:0]      act_rd_q, act_rd_d;
   logic            act_store_q, act_store_d;
   logic [2:0]      act_f3_q, act_f3_d;
   logic [1:0]      act_lo_q, act_lo_d;
   logic [4:0]      wb_sel_q, wb_sel_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;
   logic            err_misalign_q, err_misalign_d;
   logic            err_drop_q, err_drop_d;

   logic [9:0]      fifo_para_q  [DEPTH];
   logic [XLEN-1:0] fifo_addr_q  [DEPTH];
   logic [XLEN-1:0] fifo_wdata_q [DEPTH];

   logic            push;
   logic            pop;
   logic [9:0]      head_para;
   logic [XLEN-1:0] head_addr;
   logic [XLEN-1:0] head_wdata;
   logic            head_misalign;

   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         2'b00:   lane_be = 4'b0001 << lo;
         2'b01:   lane_be = 4'b0011 << lo;
         default: lane_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] rdata,
                                                input logic [1:0] lo,
                                                input logic [2:0] f3);
      logic [XLEN-1:0] sh;
      sh = rdata >> {lo, 3'b000};
      case (f3)
         3'd0:    load_ext = {{(XLEN-8){sh[7]}}, sh[7:0]};
         3'd1:    load_ext = {{(XLEN-16){sh[15]}}, sh[15:0]};
         3'd2:    load_ext = rdata;
         3'd4:    load_ext = {{(XLEN-8){1'b0}}, sh[7:0]};
         3'd5:    load_ext = {{(XLEN-16){1'b0}}, sh[15:0]};
         default: load_ext = '0;
      endcase
   endfunction

   // Space check uses the registered count only, so a same-cycle pop never admits a push.
   assign push = mem_vld && (count_q < DEPTH_C);

   assign head_para  = fifo_para_q[rd_ptr_q];
   assign head_addr  = fifo_addr_q[rd_ptr_q];
   assign head_wdata = fifo_wdata_q[rd_ptr_q];

   assign head_misalign = ((head_para[1:0] == 2'b01) && head_addr[0]) ||
                          ((head_para[1:0] == 2'b10) && (head_addr[1:0] != 2'b00));

   always_comb begin
      state_d        = state_q;
      dmem_req_d     = dmem_req_q;
      dmem_we_d      = dmem_we_q;
      dmem_addr_d    = dmem_addr_q;
      dmem_wdata_d   = dmem_wdata_q;
      dmem_be_d      = dmem_be_q;
      act_rd_d       = act_rd_q;
      act_store_d    = act_store_q;
      act_f3_d       = act_f3_q;
      act_lo_d       = act_lo_q;
      wb_sel_d       = '0;
      wb_data_d      = '0;
      err_misalign_d = 1'b0;
      err_drop_d     = mem_vld && (count_q == DEPTH_C);
      pop            = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               pop = 1'b1;
               if (head_para[9]) begin
                  err_drop_d = 1'b1;
               end else if (head_misalign) begin
                  err_misalign_d = 1'b1;
               end else begin
                  state_d      = ST_REQ;
                  dmem_req_d   = 1'b1;
                  dmem_we_d    = head_para[3];
                  dmem_addr_d  = {head_addr[XLEN-1:2], 2'b00};
                  dmem_be_d    = lane_be(head_para[1:0], head_addr[1:0]);
                  dmem_wdata_d = head_wdata << {head_addr[1:0], 3'b000};
                  act_rd_d     = head_para[8:4];
                  act_store_d  = head_para[3];
                  act_f3_d     = head_para[2:0];
                  act_lo_d     = head_addr[1:0];
               end
            end
         end
         ST_REQ: begin
            if (dmem_gnt) begin
               dmem_req_d = 1'b0;
               dmem_we_d  = 1'b0;
               state_d    = act_store_q ? ST_IDLE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (dmem_rvld) begin
               state_d   = ST_IDLE;
               wb_sel_d  = act_rd_q;
               wb_data_d = (act_rd_q != 5'd0) ? load_ext(dmem_rdata, act_lo_q, act_f3_q) : '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         count_q        <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         dmem_req_q     <= 1'b0;
         dmem_we_q      <= 1'b0;
         dmem_addr_q    <= '0;
         dmem_wdata_q   <= '0;
         dmem_be_q      <= '0;
         act_rd_q       <= '0;
         act_store_q    <= 1'b0;
         act_f3_q       <= '0;
         act_lo_q       <= '0;
         wb_sel_q       <= '0;
         wb_data_q      <= '0;
         err_misalign_q <= 1'b0;
         err_drop_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         dmem_req_q     <= dmem_req_d;
         dmem_we_q      <= dmem_we_d;
         dmem_addr_q    <= dmem_addr_d;
         dmem_wdata_q   <= dmem_wdata_d;
         dmem_be_q      <= dmem_be_d;
         act_rd_q       <= act_rd_d;
         act_store_q    <= act_store_d;
         act_f3_q       <= act_f3_d;
         act_lo_q       <= act_lo_d;
         wb_sel_q       <= wb_sel_d;
         wb_data_q      <= wb_data_d;
         err_misalign_q <= err_misalign_d;
         err_drop_q     <= err_drop_d;
      end
   end

   // Payload storage carries no reset; validity comes from count and pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_para_q[wr_ptr_q]  <= mem_para;
         fifo_addr_q[wr_ptr_q]  <= mem_addr;
         fifo_wdata_q[wr_ptr_q] <= mem_wdata;
      end
   end

   // Scoreboard of pending load destinations: queued loads plus the active one.
   always_comb begin
      busy_mask = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if ((CW'(k) < count_q) &&
             !fifo_para_q[rd_ptr_q + PW'(k)][9] && !fifo_para_q[rd_ptr_q + PW'(k)][3]) begin
            busy_mask[fifo_para_q[rd_ptr_q + PW'(k)][8:4]] = 1'b1;
         end
      end
      if (((state_q == ST_REQ) || (state_q == ST_WAIT)) && !act_store_q) begin
         busy_mask[act_rd_q] = 1'b1;
      end
      busy_mask[0] = 1'b0;
   end

   assign mmbuf_full   = (count_q == DEPTH_C);
   assign mmbuf_empty  = (count_q == '0) && (state_q == ST_IDLE);
   assign dmem_req     = dmem_req_q;
   assign dmem_we      = dmem_we_q;
   assign dmem_addr    = dmem_addr_q;
   assign dmem_wdata   = dmem_wdata_q;
   assign dmem_be      = dmem_be_q;
   assign wb_sel       = wb_sel_q;
   assign wb_data      = wb_data_q;
   assign err_misalign = err_misalign_q;
   assign err_drop     = err_drop_q;

endmodule

// File: tb/tb_mmbuf_lsu.sv
// Directed bench for mmbuf_lsu: expected bus transfers and writebacks are queued as
// requests are driven and compared by a monitor when the DUT produces them.
module tb_mmbuf_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_vld;
   logic [9:0]  mem_para;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mmbuf_full;
   logic        mmbuf_empty;
   logic [31:0] busy_mask;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_gnt;
   logic        dmem_rvld;
   logic [31:0] dmem_rdata;
   logic [4:0]  wb_sel;
   logic [31:0] wb_data;
   logic        err_misalign;
   logic        err_drop;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   typedef struct {
      logic [4:0]  sel;
      logic [31:0] data;
   } wb_t;

   bus_t exp_bus[$];
   wb_t  exp_wb[$];
   bus_t eb;
   wb_t  ew;

   int n_checks = 0;
   int n_errors = 0;
   int xfer_cnt = 0;
   int x0;

   mmbuf_lsu #(.DEPTH(4), .XLEN(32)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .mem_vld      (mem_vld),
      .mem_para     (mem_para),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mmbuf_full   (mmbuf_full),
      .mmbuf_empty  (mmbuf_empty),
      .busy_mask    (busy_mask),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_be      (dmem_be),
      .dmem_gnt     (dmem_gnt),
      .dmem_rvld    (dmem_rvld),
      .dmem_rdata   (dmem_rdata),
      .wb_sel       (wb_sel),
      .wb_data      (wb_data),
      .err_misalign (err_misalign),
      .err_drop     (err_drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic mul, input logic [4:0] rd, input logic st,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata);
      mem_vld   = 1'b1;
      mem_para  = {mul, rd, st, f3};
      mem_addr  = addr;
      mem_wdata = wdata;
      tick();
   endtask

   task automatic exp_xfer(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wdata);
      bus_t b;
      b.addr = addr; b.we = we; b.be = be; b.wdata = wdata;
      exp_bus.push_back(b);
   endtask

   task automatic exp_write(input logic [4:0] sel, input logic [31:0] data);
      wb_t w;
      w.sel = sel; w.data = data;
      exp_wb.push_back(w);
   endtask

   // Full load round trip with gnt already high.
   task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp_data);
      exp_xfer({addr[31:2], 2'b00}, 1'b0, 4'b0000, 32'h0);
      if (rd != 5'd0) exp_write(rd, exp_data);
      drive_req(1'b0, rd, 1'b0, f3, addr, 32'h0);
      mem_vld = 1'b0;
      check("load_busy_set", 64'(busy_mask[rd]), 64'(rd != 5'd0));
      tick();
      tick();
      dmem_rvld  = 1'b1;
      dmem_rdata = rdata;
      tick();
      dmem_rvld = 1'b0;
      check("load_wb_sel", 64'(wb_sel), 64'(rd));
      tick();
      check("load_wb_sel_clear", 64'(wb_sel), 64'd0);
   endtask

   // Scoreboard monitor, sampling mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (dmem_req && dmem_gnt) begin
            xfer_cnt++;
            check("bus_xfer_expected", 64'(exp_bus.size() != 0), 64'd1);
            if (exp_bus.size() != 0) begin
               eb = exp_bus.pop_front();
               check("bus_addr", 64'(dmem_addr), 64'(eb.addr));
               check("bus_we", 64'(dmem_we), 64'(eb.we));
               if (eb.we) begin
                  check("bus_be", 64'(dmem_be), 64'(eb.be));
                  check("bus_wdata", 64'(dmem_wdata), 64'(eb.wdata));
               end
            end
         end
         if (wb_sel != 5'd0) begin
            check("wb_expected", 64'(exp_wb.size() != 0), 64'd1);
            if (exp_wb.size() != 0) begin
               ew = exp_wb.pop_front();
               check("wb_sel", 64'(wb_sel), 64'(ew.sel));
               check("wb_data", 64'(wb_data), 64'(ew.data));
            end
         end
      end
   end

   initial begin
      rst        = 1'b1;
      mem_vld    = 1'b0;
      mem_para   = '0;
      mem_addr   = '0;
      mem_wdata  = '0;
      dmem_gnt   = 1'b0;
      dmem_rvld  = 1'b0;
      dmem_rdata = '0;
      tick();
      tick();
      rst = 1'b0;

      // reset state
      check("rst_empty", 64'(mmbuf_empty), 64'd1);
      check("rst_full", 64'(mmbuf_full), 64'd0);
      check("rst_busy", 64'(busy_mask), 64'd0);
      check("rst_req", 64'(dmem_req), 64'd0);
      check("rst_we", 64'(dmem_we), 64'd0);
      check("rst_wb_sel", 64'(wb_sel), 64'd0);
      check("rst_err_mis", 64'(err_misalign), 64'd0);
      check("rst_err_drop", 64'(err_drop), 64'd0);

      // store SB, immediate grant, plus two-cycle issue latency
      dmem_gnt = 1'b1;
      exp_xfer(32'h1000, 1'b1, 4'b1000, 32'hAB00_0000);
      drive_req(1'b0, 5'd4, 1'b1, 3'd0, 32'h1003, 32'h0000_00AB);
      mem_vld = 1'b0;
      check("sb_req_t1", 64'(dmem_req), 64'd0);
      tick();
      check("sb_req_t2", 64'(dmem_req), 64'd1);
      tick();
      check("sb_req_done", 64'(dmem_req), 64'd0);
      check("sb_empty", 64'(mmbuf_empty), 64'd1);
      check("sb_no_wb", 64'(wb_sel), 64'd0);

      // load LH rd=5 with busy tracking
      exp_xfer(32'h2000, 1'b0, 4'b0000, 32'h0);
      exp_write(5'd5, 32'hFFFF_80F0);
      drive_req(1'b0, 5'd5, 1'b0, 3'd1, 32'h2002, 32'h0);
      mem_vld = 1'b0;
      check("lh_busy_q", 64'(busy_mask), 64'h20);
      tick();
      check("lh_req", 64'(dmem_req), 64'd1);
      check("lh_busy_req", 64'(busy_mask[5]), 64'd1);
      tick();
      check("lh_req_wait", 64'(dmem_req), 64'd0);
      check("lh_busy_wait", 64'(busy_mask[5]), 64'd1);
      tick();
      dmem_rvld  = 1'b1;
      dmem_rdata = 32'h80F0_1234;
      check("lh_wb_pre", 64'(wb_sel), 64'd0);
      check("lh_busy_rvld", 64'(busy_mask[5]), 64'd1);
      tick();
      dmem_rvld = 1'b0;
      check("lh_wb_sel", 64'(wb_sel), 64'd5);
      check("lh_wb_data", 64'(wb_data), 64'hFFFF_80F0);
      check("lh_busy_clr", 64'(busy_mask[5]), 64'd0);
      tick();
      check("lh_wb_once", 64'(wb_sel), 64'd0);

      // remaining load extraction cases
      do_load(5'd6,  3'd0, 32'h2003, 32'h80F0_1234, 32'hFFFF_FF80);
      do_load(5'd6,  3'd4, 32'h2001, 32'h80F0_1234, 32'h0000_0012);
      do_load(5'd10, 3'd5, 32'h2002, 32'h80F0_1234, 32'h0000_80F0);
      do_load(5'd11, 3'd2, 32'h2000, 32'h80F0_1234, 32'h80F0_1234);
      do_load(5'd12, 3'd3, 32'h2000, 32'h80F0_1234, 32'h0000_0000);
      do_load(5'd13, 3'd6, 32'h2000, 32'h80F0_1234, 32'h0000_0000);
      do_load(5'd0,  3'd1, 32'h2000, 32'h80F0_1234, 32'h0000_0000);

      // misaligned LW followed by an aligned SW
      exp_xfer(32'h3004, 1'b1, 4'b1111, 32'h0000_0055);
      drive_req(1'b0, 5'd7, 1'b0, 3'd2, 32'h3001, 32'h0);
      check("mis_busy_q", 64'(busy_mask[7]), 64'd1);
      drive_req(1'b0, 5'd8, 1'b1, 3'd2, 32'h3004, 32'h0000_0055);
      mem_vld = 1'b0;
      check("mis_err", 64'(err_misalign), 64'd1);
      check("mis_no_req", 64'(dmem_req), 64'd0);
      check("mis_busy_clr", 64'(busy_mask[7]), 64'd0);
      tick();
      check("mis_err_once", 64'(err_misalign), 64'd0);
      check("mis_next_req", 64'(dmem_req), 64'd1);
      tick();
      tick();
      check("mis_no_wb", 64'(wb_sel), 64'd0);

      // mul entry consumed with err_drop, no bus access
      drive_req(1'b1, 5'd3, 1'b0, 3'd2, 32'h0000_0010, 32'h0);
      mem_vld = 1'b0;
      check("mul_not_busy", 64'(busy_mask), 64'd0);
      tick();
      check("mul_err_drop", 64'(err_drop), 64'd1);
      check("mul_no_req", 64'(dmem_req), 64'd0);
      tick();
      check("mul_err_once", 64'(err_drop), 64'd0);
      check("mul_empty", 64'(mmbuf_empty), 64'd1);

      // grant stall: SH store held 5 cycles
      dmem_gnt = 1'b0;
      exp_xfer(32'h4000, 1'b1, 4'b1100, 32'h1234_0000);
      drive_req(1'b0, 5'd1, 1'b1, 3'd1, 32'h4002, 32'h0000_1234);
      mem_vld = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("stall_req", 64'(dmem_req), 64'd1);
         check("stall_we", 64'(dmem_we), 64'd1);
         check("stall_addr", 64'(dmem_addr), 64'h4000);
         check("stall_be", 64'(dmem_be), 64'hC);
         check("stall_wdata", 64'(dmem_wdata), 64'h1234_0000);
         tick();
      end
      x0 = xfer_cnt;
      dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      check("stall_req_drop", 64'(dmem_req), 64'd0);
      tick();
      tick();
      check("stall_one_xfer", 64'(xfer_cnt - x0), 64'd1);
      check("stall_empty", 64'(mmbuf_empty), 64'd1);

      // overflow: active store stalls, then DEPTH+1 pushes
      exp_xfer(32'h0200, 1'b1, 4'b1111, 32'h0000_00A0);
      drive_req(1'b0, 5'd0, 1'b1, 3'd2, 32'h0200, 32'h0000_00A0);
      mem_vld = 1'b0;
      tick();
      check("ovf_stalled", 64'(dmem_req), 64'd1);
      for (int k = 1; k <= 5; k++) begin
         if (k <= 4) exp_xfer(32'h0300 + 32'(4 * k), 1'b1, 4'b1111, 32'(k));
         drive_req(1'b0, 5'd0, 1'b1, 3'd2, 32'h0300 + 32'(4 * k), 32'(k));
         if (k == 3) check("ovf_not_full", 64'(mmbuf_full), 64'd0);
         if (k == 4) begin
            check("ovf_full", 64'(mmbuf_full), 64'd1);
            check("ovf_no_drop_yet", 64'(err_drop), 64'd0);
         end
      end
      mem_vld = 1'b0;
      check("ovf_drop", 64'(err_drop), 64'd1);
      check("ovf_still_full", 64'(mmbuf_full), 64'd1);
      tick();
      check("ovf_drop_once", 64'(err_drop), 64'd0);
      check("ovf_addr_held", 64'(dmem_addr), 64'h0200);
      dmem_gnt = 1'b1;
      for (int i = 0; i < 40 && !mmbuf_empty; i++) tick();
      check("ovf_drained", 64'(mmbuf_empty), 64'd1);
      tick();
      tick();
      check("ovf_queue_done", 64'(exp_bus.size()), 64'd0);

      // reset while a load waits for data
      exp_xfer(32'h5000, 1'b0, 4'b0000, 32'h0);
      drive_req(1'b0, 5'd9, 1'b0, 3'd2, 32'h5000, 32'h0);
      mem_vld = 1'b0;
      tick();
      tick();
      check("rw_busy", 64'(busy_mask[9]), 64'd1);
      check("rw_waiting", 64'(mmbuf_empty), 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rw_busy_rst", 64'(busy_mask), 64'd0);
      dmem_rvld  = 1'b1;
      dmem_rdata = 32'hDEAD_BEEF;
      tick();
      dmem_rvld = 1'b0;
      check("rw_no_wb", 64'(wb_sel), 64'd0);
      tick();
      check("rw_no_wb2", 64'(wb_sel), 64'd0);
      check("rw_empty", 64'(mmbuf_empty), 64'd1);
      check("rw_busy_zero", 64'(busy_mask), 64'd0);
      check("rw_no_req", 64'(dmem_req), 64'd0);

      check("end_bus_queue", 64'(exp_bus.size()), 64'd0);
      check("end_wb_queue", 64'(exp_wb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
